ocp_arbiter2: RTL and testbench

Two-master, one-slave OCP arbiter that shares a single slave device, for example `sim_control` or a memory, between two bus masters such as the instruction fetch port and the data port of the core. It grants the slave to one master at a time using round-robin. It keeps the grant for the whole transaction: through command acceptance for writes, and through the response phase for reads. A watchdog converts a missing read response into an error response, so a dead slave cannot hang either master.

---
 rtl/ocp_arbiter2.sv | 196 +++++++++++++++++++
 tb/tb_ocp_arbiter2.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_arbiter2.sv
// ocp_arbiter2: shares one OCP slave between two masters with round-robin
// arbitration. The grant is held for the whole transaction. Writes release
// it on command accept. Reads release it when the response phase ends. A
// watchdog turns a missing read response into an ERR response, so a dead
// slave cannot hang either master.
//
// Ports
//   clk, nrst                      clock, asynchronous active-low reset
//   i_M{0,1}Addr/Cmd/Data/ByteEn   master request inputs
//   o_M{0,1}CmdAccept/Data/Resp    accept and response back to each master
//   o_SAddr/SCmd/SData/SByteEn     request to the shared slave
//   i_SCmdAccept/SData/SResp       slave accept and response
//
// FSM states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner, arbitrating between pending requests
//   ST_CMD  | granted master's command presented to the slave
//   ST_RESP | read accepted, waiting for the slave response (watchdog on)
module ocp_arbiter2 #(
    parameter int TIMEOUT    = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] i_M0Addr,
    input  logic [2:0]            i_M0Cmd,
    input  logic [DATA_WIDTH-1:0] i_M0Data,
    input  logic [BEN_WIDTH-1:0]  i_M0ByteEn,
    output logic                  o_M0CmdAccept,
    output logic [DATA_WIDTH-1:0] o_M0Data,
    output logic [1:0]            o_M0Resp,
    input  logic [ADDR_WIDTH-1:0] i_M1Addr,
    input  logic [2:0]            i_M1Cmd,
    input  logic [DATA_WIDTH-1:0] i_M1Data,
    input  logic [BEN_WIDTH-1:0]  i_M1ByteEn,
    output logic                  o_M1CmdAccept,
    output logic [DATA_WIDTH-1:0] o_M1Data,
    output logic [1:0]            o_M1Resp,
    output logic [ADDR_WIDTH-1:0] o_SAddr,
    output logic [2:0]            o_SCmd,
    output logic [DATA_WIDTH-1:0] o_SData,
    output logic [BEN_WIDTH-1:0]  o_SByteEn,
    input  logic                  i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic [1:0]            i_SResp
);

    localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
    localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
    localparam logic [2:0] OCP_CMD_READ  = 3'b010;
    localparam logic [1:0] OCP_RESP_NULL = 2'b00;
    localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
    localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

    localparam int              WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state;
    logic            grant;
    logic            last;
    logic            is_rd;
    logic [WD_W-1:0] wd;

    logic                  req0;
    logic                  req1;
    logic                  nxt_grant;
    logic [2:0]            nxt_cmd;
    logic [2:0]            g_cmd;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_data;
    logic [BEN_WIDTH-1:0]  g_ben;
    logic                  wd_expired;
    logic                  acc;
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] rdata;

    assign req0 = (i_M0Cmd != OCP_CMD_IDLE);
    assign req1 = (i_M1Cmd != OCP_CMD_IDLE);

    // On a tie the master not served last wins; otherwise the lone requester.
    assign nxt_grant = (req0 && req1) ? ~last : req1;
    assign nxt_cmd   = nxt_grant ? i_M1Cmd : i_M0Cmd;

    assign g_cmd  = grant ? i_M1Cmd    : i_M0Cmd;
    assign g_addr = grant ? i_M1Addr   : i_M0Addr;
    assign g_data = grant ? i_M1Data   : i_M0Data;
    assign g_ben  = grant ? i_M1ByteEn : i_M0ByteEn;

    assign wd_expired = (state == ST_RESP) && (wd == WD_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
            is_rd <= 1'b0;
            wd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        grant <= nxt_grant;
                        is_rd <= (nxt_cmd == OCP_CMD_READ);
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // A master withdrawing its command before accept is a
                    // protocol violation: drop it without touching fairness.
                    if (g_cmd == OCP_CMD_IDLE) begin
                        state <= ST_IDLE;
                    end else if (i_SCmdAccept) begin
                        last <= grant;
                        if (is_rd) begin
                            wd    <= '0;
                            state <= ST_RESP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RESP: begin
                    if ((i_SResp != OCP_RESP_NULL) || wd_expired) begin
                        state <= ST_IDLE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Slave side: only the CMD state drives a command.
    always_comb begin
        o_SCmd    = OCP_CMD_IDLE;
        o_SAddr   = '0;
        o_SData   = '0;
        o_SByteEn = '0;
        if (state == ST_CMD) begin
            o_SCmd    = g_cmd;
            o_SAddr   = g_addr;
            o_SData   = g_data;
            o_SByteEn = g_ben;
        end
    end

    // Response path: forward the slave unchanged unless the watchdog fires
    // in a cycle where the slave is still silent.
    always_comb begin
        acc   = (state == ST_CMD) && i_SCmdAccept;
        resp  = OCP_RESP_NULL;
        rdata = '0;
        if (state == ST_RESP) begin
            if (wd_expired && (i_SResp == OCP_RESP_NULL)) begin
                resp  = OCP_RESP_ERR;
                rdata = '0;
            end else begin
                resp  = i_SResp;
                rdata = i_SData;
            end
        end
    end

    always_comb begin
        o_M0CmdAccept = 1'b0;
        o_M0Resp      = OCP_RESP_NULL;
        o_M0Data      = '0;
        o_M1CmdAccept = 1'b0;
        o_M1Resp      = OCP_RESP_NULL;
        o_M1Data      = '0;
        if (grant) begin
            o_M1CmdAccept = acc;
            o_M1Resp      = resp;
            o_M1Data      = rdata;
        end else begin
            o_M0CmdAccept = acc;
            o_M0Resp      = resp;
            o_M0Data      = rdata;
        end
    end

    // Only referenced to document the encoding set; keeps the constant used.
    logic unused_dva;
    assign unused_dva = (OCP_RESP_DVA == 2'b01) && (OCP_CMD_WRITE == 3'b001);

endmodule

// File: tb/tb_ocp_arbiter2.sv
// Directed bench for ocp_arbiter2 with TIMEOUT = 8. Expected slave requests
// and master responses are queued when stimulus is driven and popped when
// the DUT presents them; directed checks cover latency, reset and aborts.
module tb_ocp_arbiter2;

    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_WR   = 3'd1;
    localparam logic [2:0] C_RD   = 3'd2;
    localparam logic [1:0] R_NULL = 2'd0;
    localparam logic [1:0] R_DVA  = 2'd1;
    localparam logic [1:0] R_ERR  = 2'd3;

    logic        clk;
    logic        nrst;
    logic [31:0] i_M0Addr, i_M1Addr, i_M0Data, i_M1Data;
    logic [2:0]  i_M0Cmd, i_M1Cmd;
    logic [3:0]  i_M0ByteEn, i_M1ByteEn;
    logic        o_M0CmdAccept, o_M1CmdAccept;
    logic [31:0] o_M0Data, o_M1Data;
    logic [1:0]  o_M0Resp, o_M1Resp;
    logic [31:0] o_SAddr, o_SData;
    logic [2:0]  o_SCmd;
    logic [3:0]  o_SByteEn;
    logic        i_SCmdAccept;
    logic [31:0] i_SData;
    logic [1:0]  i_SResp;

    ocp_arbiter2 #(.TIMEOUT(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4)) dut (
        .clk(clk), .nrst(nrst),
        .i_M0Addr(i_M0Addr), .i_M0Cmd(i_M0Cmd), .i_M0Data(i_M0Data), .i_M0ByteEn(i_M0ByteEn),
        .o_M0CmdAccept(o_M0CmdAccept), .o_M0Data(o_M0Data), .o_M0Resp(o_M0Resp),
        .i_M1Addr(i_M1Addr), .i_M1Cmd(i_M1Cmd), .i_M1Data(i_M1Data), .i_M1ByteEn(i_M1ByteEn),
        .o_M1CmdAccept(o_M1CmdAccept), .o_M1Data(o_M1Data), .o_M1Resp(o_M1Resp),
        .o_SAddr(o_SAddr), .o_SCmd(o_SCmd), .o_SData(o_SData), .o_SByteEn(o_SByteEn),
        .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData), .i_SResp(i_SResp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        m;
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } sq_t;

    sq_t         sq[$];
    logic [33:0] rq0[$];
    logic [33:0] rq1[$];
    int          total = 0;
    int          bad   = 0;

    function automatic sq_t mk(input logic m, input logic [2:0] c,
                               input logic [31:0] a, input logic [31:0] d);
        sq_t e;
        e.m    = m;
        e.cmd  = c;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard whenever the DUT completes a slave command or
    // delivers a response to a master.
    task automatic sample();
        sq_t         e;
        logic [33:0] r;
        if (o_SCmd != C_IDLE && i_SCmdAccept) begin
            if (sq.size() == 0) begin
                chk("slv_unexpected", {o_SCmd, o_SAddr}, 0);
            end else begin
                e = sq.pop_front();
                chk("slv_req", {o_SCmd, o_SAddr, o_SData}, {e.cmd, e.addr, e.data});
                chk("slv_owner", {o_M1CmdAccept, o_M0CmdAccept}, {e.m, ~e.m});
            end
        end
        if (o_M0Resp != R_NULL) begin
            if (rq0.size() == 0) chk("m0_resp_unexpected", {o_M0Resp, o_M0Data}, 0);
            else begin
                r = rq0.pop_front();
                chk("m0_resp", {o_M0Resp, o_M0Data}, r);
            end
        end
        if (o_M1Resp != R_NULL) begin
            if (rq1.size() == 0) chk("m1_resp_unexpected", {o_M1Resp, o_M1Data}, 0);
            else begin
                r = rq1.pop_front();
                chk("m1_resp", {o_M1Resp, o_M1Data}, r);
            end
        end
    endtask

    task automatic cyc();
        sample();
        @(negedge clk);
    endtask

    task automatic drv(input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] d1);
        i_M0Cmd  = c0;
        i_M0Addr = a0;
        i_M0Data = d0;
        i_M1Cmd  = c1;
        i_M1Addr = a1;
        i_M1Data = d1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nrst         = 1'b0;
        i_M0ByteEn   = 4'hF;
        i_M1ByteEn   = 4'h3;
        i_SCmdAccept = 1'b0;
        i_SResp      = R_NULL;
        i_SData      = '0;
        drv(C_IDLE, 0, 0, C_IDLE, 0, 0);
        @(negedge clk);

        // Reset held while masters and slave toggle: everything stays 0.
        for (int k = 0; k < 3; k++) begin
            drv(k[0] ? C_WR : C_RD, 32'h4, 32'h5, k[0] ? C_RD : C_WR, 32'h6, 32'h7);
            i_SCmdAccept = 1'b1;
            i_SResp      = R_DVA;
            i_SData      = 32'h99;
            #1;
            chk("rst_scmd", o_SCmd, C_IDLE);
            chk("rst_sreq", {o_SAddr, o_SData, o_SByteEn}, 0);
            chk("rst_m0", {o_M0CmdAccept, o_M0Resp, o_M0Data}, 0);
            chk("rst_m1", {o_M1CmdAccept, o_M1Resp, o_M1Data}, 0);
            @(negedge clk);
        end

        // Release reset with an M0 write pending; accepted immediately.
        nrst    = 1'b1;
        i_SResp = R_NULL;
        i_SData = '0;
        drv(C_WR, 32'h0, 32'h000FFFF0, C_IDLE, 0, 0);
        sq.push_back(mk(1'b0, C_WR, 32'h0, 32'h000FFFF0));
        #1; chk("lat_idle", o_SCmd, C_IDLE); cyc();
        #1;
        chk("wr_scmd", o_SCmd, C_WR);
        chk("wr_ben", o_SByteEn, 4'hF);
        chk("wr_acc0", o_M0CmdAccept, 1'b1);
        chk("wr_m1_quiet", {o_M1CmdAccept, o_M1Resp, o_M1Data}, 0);
        cyc();
        drv(C_IDLE, 0, 0, C_IDLE, 0, 0);
        #1; chk("wr_acc_once", o_M0CmdAccept, 1'b0); cyc();

        // M1 read, DVA two cycles after accept.
        drv(C_IDLE, 0, 0, C_RD, 32'h0, 32'h0);
        sq.push_back(mk(1'b1, C_RD, 32'h0, 32'h0));
        rq1.push_back({R_DVA, 32'h000FFFF0});
        #1; cyc();
        #1; chk("rd_scmd", o_SCmd, C_RD); cyc();
        drv(C_IDLE, 0, 0, C_IDLE, 0, 0);
        i_SCmdAccept = 1'b0;
        #1;
        chk("rd_wait_null", o_M1Resp, R_NULL);
        chk("rd_no_new_cmd", o_SCmd, C_IDLE);
        cyc();
        i_SResp = R_DVA;
        i_SData = 32'h000FFFF0;
        #1;
        chk("rd_m1resp", o_M1Resp, R_DVA);
        chk("rd_m1data", o_M1Data, 32'h000FFFF0);
        chk("rd_m0_null", {o_M0Resp, o_M0Data}, 0);
        cyc();
        i_SResp = R_NULL;
        i_SData = '0;
        #1; cyc();

        // Round-robin: both masters write continuously; M1 was served last.
        i_SCmdAccept = 1'b1;
        sq.push_back(mk(1'b0, C_WR, 32'h10, 32'hA0000000));
        sq.push_back(mk(1'b1, C_WR, 32'h20, 32'hB0000000));
        sq.push_back(mk(1'b0, C_WR, 32'h10, 32'hA0000001));
        sq.push_back(mk(1'b1, C_WR, 32'h20, 32'hB0000001));
        for (int i = 0; i < 4; i++) begin
            drv(C_WR, 32'h10, 32'hA0000000 + 32'((i + 1) / 2),
                C_WR, 32'h20, 32'hB0000000 + 32'(i / 2));
            #1; chk("rr_arb_gap", o_SCmd, C_IDLE); cyc();
            #1; chk("rr_owner", {o_M1CmdAccept, o_M0CmdAccept}, {i[0], ~i[0]}); cyc();
        end
        drv(C_IDLE, 0, 0, C_IDLE, 0, 0);
        #1; cyc();

        // Watchdog: M0 read never answered while M1 waits with a write.
        sq.push_back(mk(1'b0, C_RD, 32'h30, 32'h0));
        rq0.push_back({R_ERR, 32'h0});
        sq.push_back(mk(1'b1, C_WR, 32'h40, 32'hC0));
        drv(C_RD, 32'h30, 32'h0, C_WR, 32'h40, 32'hC0);
        #1; cyc();
        #1; chk("wd_grant0", o_M0CmdAccept, 1'b1); cyc();
        drv(C_IDLE, 0, 0, C_WR, 32'h40, 32'hC0);
        i_SCmdAccept = 1'b0;
        i_SData      = 32'hDEADBEEF;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (k < 8) begin
                chk("wd_wait", o_M0Resp, R_NULL);
            end else begin
                chk("wd_err", o_M0Resp, R_ERR);
                chk("wd_err_data", o_M0Data, 32'h0);
            end
            chk("wd_no_new_cmd", o_SCmd, C_IDLE);
            cyc();
        end
        i_SResp      = R_DVA;
        i_SData      = 32'h1234;
        i_SCmdAccept = 1'b1;
        #1;
        chk("late_m0", {o_M0Resp, o_M0Data}, 0);
        chk("late_m1", {o_M1Resp, o_M1Data}, 0);
        cyc();
        #1; chk("wd_next_m1", o_M1CmdAccept, 1'b1); cyc();
        drv(C_IDLE, 0, 0, C_IDLE, 0, 0);
        i_SResp = R_NULL;
        i_SData = '0;
        #1; cyc();

        // Reset asserted during RESP aborts with no response.
        sq.push_back(mk(1'b0, C_RD, 32'h50, 32'h0));
        drv(C_RD, 32'h50, 32'h0, C_IDLE, 0, 0);
        #1; cyc();
        #1; cyc();
        drv(C_IDLE, 0, 0, C_IDLE, 0, 0);
        i_SCmdAccept = 1'b0;
        i_SData      = 32'h77;
        #1; chk("ab_fwd_data", o_M0Data, 32'h77);
        #1;
        nrst    = 1'b0;
        i_SResp = R_DVA;
        #1;
        chk("ab_rst_m0", {o_M0Resp, o_M0Data}, 0);
        chk("ab_rst_scmd", o_SCmd, C_IDLE);
        @(negedge clk);
        i_SResp = R_NULL;
        i_SData = '0;
        nrst    = 1'b1;
        #1; cyc();

        // M0 drops its command in CMD: abort, fairness untouched.
        drv(C_WR, 32'h60, 32'h66, C_IDLE, 0, 0);
        #1; cyc();
        #1;
        chk("ca_scmd", o_SCmd, C_WR);
        chk("ca_no_acc", o_M0CmdAccept, 1'b0);
        cyc();
        drv(C_IDLE, 0, 0, C_IDLE, 0, 0);
        #1; chk("ca_drop", o_SCmd, C_IDLE); cyc();
        sq.push_back(mk(1'b0, C_WR, 32'h60, 32'h70));
        drv(C_WR, 32'h60, 32'h70, C_WR, 32'h61, 32'h71);
        i_SCmdAccept = 1'b1;
        #1; chk("ca_back_idle", o_SCmd, C_IDLE); cyc();
        #1; chk("ca_tie_m0", {o_M1CmdAccept, o_M0CmdAccept}, 2'b01); cyc();
        drv(C_IDLE, 0, 0, C_IDLE, 0, 0);
        #1; cyc();

        chk("sq_drained", sq.size(), 0);
        chk("rq0_drained", rq0.size(), 0);
        chk("rq1_drained", rq1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
